// File: rtl/pipelined_result_rounder.sv
// Two-stage IEEE-style result rounder (5 modes, inexact/overflow flags); 2-cycle latency, 1/cycle, valid/ready stall holds both stages.
// Optional saturating status counters are compiled in with `define ROUNDER_STATUS_COUNTERS_EN.
module pipelined_result_rounder #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int ROUNDING_BITS  = 3,
  parameter int COUNTER_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXPONENT_WIDTH-1:0] in_exponent,
  input  logic [MANTISSA_WIDTH-1:0] in_mantissa,
  input  logic [ROUNDING_BITS-1:0]  in_rounding_bits,
  input  logic [2:0]                in_rounding_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sign,
  output logic [EXPONENT_WIDTH-1:0] out_exponent,
  output logic [MANTISSA_WIDTH-1:0] out_mantissa,
  output logic                      out_inexact,
  output logic                      out_overflow
`ifdef ROUNDER_STATUS_COUNTERS_EN
  ,
  output logic [COUNTER_WIDTH-1:0]  inexact_count,
  output logic [COUNTER_WIDTH-1:0]  overflow_count
`endif
);

  localparam logic [2:0] MODE_RTZ = 3'b001;
  localparam logic [2:0] MODE_RDN = 3'b010;
  localparam logic [2:0] MODE_RUP = 3'b011;
  localparam logic [2:0] MODE_RMM = 3'b100;

  // Stage-1 payload: mantissa already incremented, carry kept in the top bit.
  typedef struct packed {
    logic                      sign;
    logic [EXPONENT_WIDTH-1:0] exponent;
    logic [MANTISSA_WIDTH:0]   mant_sum;
    logic                      inexact;
  } s1_t;

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  s1_t  s1_d;
  s1_t  s1_q;

  logic guard;
  logic sticky;
  logic special;
  logic inexact_raw;
  logic round_up;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_comb begin
    guard       = in_rounding_bits[ROUNDING_BITS-1];
    sticky      = |in_rounding_bits[ROUNDING_BITS-2:0];
    special     = &in_exponent;
    inexact_raw = guard | sticky;
    case (in_rounding_mode)
      MODE_RTZ: round_up = 1'b0;
      MODE_RDN: round_up = inexact_raw & in_sign;
      MODE_RUP: round_up = inexact_raw & !in_sign;
      MODE_RMM: round_up = guard;
      default:  round_up = guard & (sticky | in_mantissa[0]);
    endcase
    // Inf/NaN pass through untouched and never raise flags.
    if (special) begin
      round_up    = 1'b0;
      inexact_raw = 1'b0;
    end
    s1_d.sign     = in_sign;
    s1_d.exponent = in_exponent;
    s1_d.mant_sum = {1'b0, in_mantissa} + (MANTISSA_WIDTH+1)'(round_up);
    s1_d.inexact  = inexact_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  logic                      carry;
  logic [EXPONENT_WIDTH-1:0] exp_inc;
  logic [EXPONENT_WIDTH-1:0] exp_nxt;
  logic [MANTISSA_WIDTH-1:0] mant_nxt;
  logic                      ovf_nxt;

  always_comb begin
    carry   = s1_q.mant_sum[MANTISSA_WIDTH];
    exp_inc = s1_q.exponent + EXPONENT_WIDTH'(1);
    if (carry) begin
      exp_nxt  = exp_inc;
      mant_nxt = '0;
      ovf_nxt  = &exp_inc;
    end else begin
      exp_nxt  = s1_q.exponent;
      mant_nxt = s1_q.mant_sum[MANTISSA_WIDTH-1:0];
      ovf_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      out_sign     <= 1'b0;
      out_exponent <= '0;
      out_mantissa <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sign     <= s1_q.sign;
        out_exponent <= exp_nxt;
        out_mantissa <= mant_nxt;
        out_inexact  <= s1_q.inexact;
        out_overflow <= ovf_nxt;
      end
    end
  end

`ifdef ROUNDER_STATUS_COUNTERS_EN
  // Counted on the output handshake so a stalled result is counted once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inexact_count  <= '0;
      overflow_count <= '0;
    end else if (s2_valid && out_ready) begin
      if (out_inexact && !(&inexact_count))   inexact_count  <= inexact_count + COUNTER_WIDTH'(1);
      if (out_overflow && !(&overflow_count)) overflow_count <= overflow_count + COUNTER_WIDTH'(1);
    end
  end
`endif

endmodule
